// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game round controller.
// Holds the round state encoding, the measurement widths and a small min helper.
package reaction_pkg;

    localparam int MS_W   = 14;
    localparam int RAND_W = 12;
    localparam logic [MS_W-1:0] MAX_MS = 14'd9999;

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        SETTLE,
        WAIT,
        REACT,
        DONE
    } state_e;

    function automatic logic [MS_W-1:0] minMs(input logic [MS_W-1:0] a,
                                              input logic [MS_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: emits a one-cycle tick every DIV clocks.
// A restart pulse realigns the count so the first tick lands DIV cycles later.
module ms_tick_gen #(
    parameter int DIV = 50_000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reaction_round_ctrl.sv
// Round controller: draws a random delay from the LFSR, lights GO and times the press.
// Optional BEST_TIME_EN adds a best_ms output tracking the fastest valid round.
module reaction_round_ctrl
    import reaction_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int MIN_DELAY = 500,
    parameter int MAX_TRIES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              btn,
    input  logic [RAND_W-1:0] rand_val,
    input  logic              rand_ready,
    output logic              lfsr_step,
    output logic              busy,
    output logic              go_led,
    output logic [MS_W-1:0]   react_ms,
    output logic              result_valid,
    output logic              false_start,
    output logic              timeout
`ifdef BEST_TIME_EN
    ,
    output logic [MS_W-1:0]   best_ms
`endif
);

    localparam int TRY_W = (MAX_TRIES > 2) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0]  LAST_TRY  = TRY_W'(MAX_TRIES - 1);
    localparam logic [RAND_W-1:0] MIN_DLY_V = RAND_W'(MIN_DELAY);

    state_e            state_q, state_d;
    logic              btn_q;
    logic [TRY_W-1:0]  tries_q, tries_d;
    logic [RAND_W-1:0] delay_q, delay_d;
    logic [MS_W-1:0]   react_q, react_d;
    logic              valid_q, valid_d;
    logic              false_q, false_d;
    logic              tmo_q, tmo_d;
    logic              btn_rise;
    logic              tick;
    logic              restart;

    assign btn_rise = btn & ~btn_q;

    ms_tick_gen #(
        .DIV(CLK_HZ / 1000)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    // A press always beats a same-cycle tick, so the reported time never advances on the press cycle.
    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        delay_d = delay_q;
        react_d = react_q;
        valid_d = valid_q;
        false_d = false_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = STEP;
                    tries_d = '0;
                    react_d = '0;
                    valid_d = 1'b0;
                    false_d = 1'b0;
                    tmo_d   = 1'b0;
                end
            end
            STEP: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                if (rand_ready) begin
                    delay_d = rand_val;
                    state_d = WAIT;
                end else if (tries_q < LAST_TRY) begin
                    tries_d = tries_q + TRY_W'(1);
                    state_d = STEP;
                end else begin
                    delay_d = MIN_DLY_V;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (btn_rise) begin
                    false_d = 1'b1;
                    react_d = '0;
                    state_d = DONE;
                end else if (tick) begin
                    if (delay_q <= RAND_W'(1)) begin
                        state_d = REACT;
                    end else begin
                        delay_d = delay_q - RAND_W'(1);
                    end
                end
            end
            REACT: begin
                if (btn_rise) begin
                    valid_d = 1'b1;
                    state_d = DONE;
                end else if (tick) begin
                    if (react_q >= MAX_MS - MS_W'(1)) begin
                        react_d = MAX_MS;
                        tmo_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        react_d = react_q + MS_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        restart = (state_d != state_q) && ((state_d == WAIT) || (state_d == REACT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            btn_q   <= 1'b0;
            tries_q <= '0;
            delay_q <= '0;
            react_q <= '0;
            valid_q <= 1'b0;
            false_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            btn_q   <= btn;
            tries_q <= tries_d;
            delay_q <= delay_d;
            react_q <= react_d;
            valid_q <= valid_d;
            false_q <= false_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef BEST_TIME_EN
    logic [MS_W-1:0] best_q, best_d;

    // Only a genuine press in REACT can improve the record.
    always_comb begin
        best_d = best_q;
        if ((state_q == REACT) && btn_rise) begin
            best_d = minMs(best_q, react_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_q <= MAX_MS;
        end else begin
            best_q <= best_d;
        end
    end

    assign best_ms = best_q;
`endif

    assign lfsr_step    = (state_q == STEP);
    assign busy         = (state_q != IDLE) && (state_q != DONE);
    assign go_led       = (state_q == REACT);
    assign react_ms     = react_q;
    assign result_valid = valid_q;
    assign false_start  = false_q;
    assign timeout      = tmo_q;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Directed bench for reaction_round_ctrl at 4 clocks per ms, with a tiny LFSR stand-in.
// Define BEST_TIME_EN to also exercise the best_ms tracking.
module tb_reaction_round_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        btn;
    logic        rand_ready = 1'b0;
    logic [11:0] rand_val = 12'd0;
    logic        lfsr_step;
    logic        busy;
    logic        go_led;
    logic [13:0] react_ms;
    logic        result_valid;
    logic        false_start;
    logic        timeout;
`ifdef BEST_TIME_EN
    logic [13:0] best_ms;
`endif

    int stepCount  = 0;
    int roundBase  = 0;
    int lfsrMode   = 0;
    int checkCount = 0;
    int errorCount = 0;

    reaction_round_ctrl #(
        .CLK_HZ(4000),
        .MIN_DELAY(500),
        .MAX_TRIES(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .btn         (btn),
        .rand_val    (rand_val),
        .rand_ready  (rand_ready),
        .lfsr_step   (lfsr_step),
        .busy        (busy),
        .go_led      (go_led),
        .react_ms    (react_ms),
        .result_valid(result_valid),
        .false_start (false_start),
        .timeout     (timeout)
`ifdef BEST_TIME_EN
        ,
        .best_ms     (best_ms)
`endif
    );

    always #5 clk = ~clk;

    // LFSR stand-in: mode 0 always 700 ready, mode 1 three misses then 512, mode 2 stuck at zero.
    always @(posedge clk) begin
        if (lfsr_step) begin
            stepCount <= stepCount + 1;
            case (lfsrMode)
                0: begin
                    rand_ready <= 1'b1;
                    rand_val   <= 12'd700;
                end
                1: begin
                    if (stepCount + 1 - roundBase <= 3) begin
                        rand_ready <= 1'b0;
                        rand_val   <= 12'd100;
                    end else begin
                        rand_ready <= 1'b1;
                        rand_val   <= 12'd512;
                    end
                end
                default: begin
                    rand_ready <= 1'b0;
                    rand_val   <= 12'd0;
                end
            endcase
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=expired expected=finished");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Called on a falling edge; returns on the falling edge inside the first STEP cycle.
    task automatic applyStimulus();
        roundBase = stepCount;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitGo(input int startCount, input int budget, output int cycles);
        cycles = startCount;
        while (go_led !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic applyReset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        int goSeen;
        int baseSteps;

        start = 1'b0;
        btn   = 1'b0;
        @(negedge clk);
        applyReset();

        $display("[TB] reset state");
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_go", go_led, 0);
        checkOutput("rst_step", lfsr_step, 0);
        checkOutput("rst_react", react_ms, 0);
        checkOutput("rst_valid", result_valid, 0);
        checkOutput("rst_false", false_start, 0);
        checkOutput("rst_timeout", timeout, 0);
`ifdef BEST_TIME_EN
        checkOutput("rst_best", best_ms, 9999);
`endif

        $display("[TB] normal round, delay 700 ms, press at 37 ms");
        lfsrMode = 0;
        applyStimulus();
        checkOutput("n_step_pulse", lfsr_step, 1);
        checkOutput("n_busy", busy, 1);
        waitGo(0, 5000, cyc);
        checkOutput("n_go_cycles", cyc, 2802);
        checkOutput("n_pulses", stepCount - roundBase, 1);
        repeat (148) @(negedge clk);
        btn = 1'b1;
        @(negedge clk);
        checkOutput("n_react", react_ms, 37);
        checkOutput("n_valid", result_valid, 1);
        checkOutput("n_false", false_start, 0);
        checkOutput("n_timeout", timeout, 0);
        checkOutput("n_go_off", go_led, 0);
        checkOutput("n_busy_off", busy, 0);
        btn = 1'b0;
        @(negedge clk);

        $display("[TB] retry round, three misses then 512 ms, press on first GO cycle");
        lfsrMode = 1;
        applyStimulus();
        waitGo(0, 5000, cyc);
        checkOutput("r_go_cycles", cyc, 2056);
        checkOutput("r_pulses", stepCount - roundBase, 4);
        btn = 1'b1;
        @(negedge clk);
        checkOutput("r_react0", react_ms, 0);
        checkOutput("r_valid", result_valid, 1);
        btn = 1'b0;
        @(negedge clk);

        $display("[TB] lock-up round, fallback to 500 ms");
        lfsrMode = 2;
        applyStimulus();
        waitGo(0, 5000, cyc);
        checkOutput("l_go_cycles", cyc, 2032);
        checkOutput("l_pulses", stepCount - roundBase, 16);
        repeat (20) @(negedge clk);
        btn = 1'b1;
        @(negedge clk);
        checkOutput("l_react", react_ms, 5);
        btn = 1'b0;
        @(negedge clk);

        $display("[TB] false start 10 ms into the wait");
        lfsrMode = 0;
        applyStimulus();
        goSeen = 0;
        repeat (42) begin
            @(negedge clk);
            goSeen = goSeen | int'(go_led);
        end
        btn = 1'b1;
        @(negedge clk);
        checkOutput("f_false", false_start, 1);
        checkOutput("f_react", react_ms, 0);
        checkOutput("f_valid", result_valid, 0);
        checkOutput("f_busy", busy, 0);
        repeat (3000) begin
            @(negedge clk);
            goSeen = goSeen | int'(go_led);
        end
        checkOutput("f_go_never", goSeen, 0);
        checkOutput("f_false_held", false_start, 1);

        $display("[TB] button held across start does not count");
        applyStimulus();
        checkOutput("h_false_clr", false_start, 0);
        waitGo(0, 5000, cyc);
        checkOutput("h_go_cycles", cyc, 2802);
        btn = 1'b0;
        repeat (8) @(negedge clk);
        btn = 1'b1;
        @(negedge clk);
        checkOutput("h_react", react_ms, 2);
        checkOutput("h_valid", result_valid, 1);
        btn = 1'b0;
        @(negedge clk);

        $display("[TB] timeout round after reset");
        applyReset();
        applyStimulus();
        waitGo(0, 5000, cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 45000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("t_cycles", cyc, 39996);
        checkOutput("t_react", react_ms, 9999);
        checkOutput("t_timeout", timeout, 1);
        checkOutput("t_valid", result_valid, 0);
        checkOutput("t_false", false_start, 0);
`ifdef BEST_TIME_EN
        checkOutput("b_after_timeout", best_ms, 9999);
        applyStimulus();
        waitGo(0, 5000, cyc);
        repeat (148) @(negedge clk);
        btn = 1'b1;
        @(negedge clk);
        checkOutput("b_react37", react_ms, 37);
        checkOutput("b_best37", best_ms, 37);
        btn = 1'b0;
        @(negedge clk);
        applyStimulus();
        waitGo(0, 5000, cyc);
        repeat (208) @(negedge clk);
        btn = 1'b1;
        @(negedge clk);
        checkOutput("b_react52", react_ms, 52);
        checkOutput("b_best_keep", best_ms, 37);
        btn = 1'b0;
        @(negedge clk);
`endif

        $display("[TB] start ignored while busy, then reset during GO");
        applyStimulus();
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitGo(11, 5000, cyc);
        checkOutput("x_go_cycles", cyc, 2802);
        checkOutput("x_pulses", stepCount - roundBase, 1);
        repeat (20) @(negedge clk);
        checkOutput("x_react_pre", react_ms, 5);
        reset = 1'b1;
        #1;
        checkOutput("x_go_async", go_led, 0);
        checkOutput("x_busy_async", busy, 0);
        checkOutput("x_react_async", react_ms, 0);
        @(negedge clk);
        reset = 1'b0;
        baseSteps = stepCount;
        repeat (10) @(negedge clk);
        checkOutput("x_idle_busy", busy, 0);
        checkOutput("x_idle_go", go_led, 0);
        checkOutput("x_idle_steps", stepCount - baseSteps, 0);
        checkOutput("x_idle_valid", result_valid, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
